load_cache_arbiter: RTL and testbench

Shares the single data-cache read port between REQ_NUM load reservation stations. Each requester is one load_RS instance, indexed by its fuindex offset. The block grants requests round-robin, drives c_ptr/c_read_enable, and waits MEM_STALL cycles on a miss. It returns the loaded word with a one-hot, one-cycle ack, so load RSs no longer touch the cache directly.

---
 rtl/load_cache_arbiter.sv | 148 ++++++++++++++
 tb/tb_load_cache_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_cache_arbiter.sv
// Round-robin arbiter sharing one data-cache read port among REQ_NUM load RSs.
// Hit returns in 2 cycles, miss in 2+MEM_STALL; the ack is a one-hot, one-cycle pulse.
module load_cache_arbiter #(
   parameter int REQ_NUM   = 4,
   parameter int WORD_SIZE = 32,
   parameter int MEM_STALL = 4,
   parameter int CNT_W     = 3
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [REQ_NUM-1:0]             req,
   input  logic [REQ_NUM*WORD_SIZE-1:0]   req_addr,
   output logic [REQ_NUM-1:0]             ack,
   output logic [WORD_SIZE-1:0]           rdata,
   output logic                           busy,
   output logic [WORD_SIZE-1:0]           c_ptr,
   output logic                           c_read_enable,
   input  logic [WORD_SIZE-1:0]           c_out,
   input  logic                           c_hit
);

   localparam int IDX_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(REQ_NUM - 1);
   localparam logic [CNT_W-1:0] STALL_INIT = CNT_W'(MEM_STALL - 1);

   typedef enum logic [1:0] {IDLE, LOOKUP, STALL} state_t;

   state_t                 state, state_nxt;
   logic [IDX_W-1:0]       grant, grant_nxt;
   logic [IDX_W-1:0]       last_grant, last_grant_nxt;
   logic [CNT_W-1:0]       count, count_nxt;
   logic [REQ_NUM-1:0]     ack_nxt;
   logic [WORD_SIZE-1:0]   rdata_nxt;
   logic [WORD_SIZE-1:0]   c_ptr_nxt;
   logic                   c_read_enable_nxt;
   logic                   busy_nxt;

   logic [WORD_SIZE-1:0]   addr_arr [REQ_NUM];
   logic [REQ_NUM-1:0]     eligible;
   logic [IDX_W-1:0]       pick;
   logic [IDX_W-1:0]       cand;
   logic                   found;
   int                     wrap_sum;

   always_comb begin
      for (int i = 0; i < REQ_NUM; i++) begin
         addr_arr[i] = req_addr[i*WORD_SIZE +: WORD_SIZE];
      end
   end

   // A requester whose ack is visible this cycle is masked so a late-dropping req is not regranted.
   always_comb begin
      eligible = req & ~ack;
      found    = 1'b0;
      pick     = last_grant;
      cand     = '0;
      wrap_sum = 0;
      for (int k = 1; k <= REQ_NUM; k++) begin
         wrap_sum = int'(last_grant) + k;
         if (wrap_sum >= REQ_NUM) wrap_sum = wrap_sum - REQ_NUM;
         cand = IDX_W'(wrap_sum);
         if (!found && eligible[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_comb begin
      state_nxt         = state;
      grant_nxt         = grant;
      last_grant_nxt    = last_grant;
      count_nxt         = count;
      ack_nxt           = '0;
      rdata_nxt         = rdata;
      c_ptr_nxt         = c_ptr;
      c_read_enable_nxt = c_read_enable;
      case (state)
         IDLE: begin
            if (found) begin
               grant_nxt         = pick;
               last_grant_nxt    = pick;
               c_ptr_nxt         = addr_arr[pick];
               c_read_enable_nxt = 1'b1;
               state_nxt         = LOOKUP;
            end
         end
         LOOKUP: begin
            if (!req[grant]) begin
               c_read_enable_nxt = 1'b0;
               state_nxt         = IDLE;
            end else if (c_hit) begin
               rdata_nxt         = c_out;
               ack_nxt[grant]    = 1'b1;
               c_read_enable_nxt = 1'b0;
               state_nxt         = IDLE;
            end else begin
               count_nxt = STALL_INIT;
               state_nxt = STALL;
            end
         end
         STALL: begin
            // After the stall window the data is taken regardless of c_hit.
            if (!req[grant]) begin
               c_read_enable_nxt = 1'b0;
               state_nxt         = IDLE;
            end else if (count == '0) begin
               rdata_nxt         = c_out;
               ack_nxt[grant]    = 1'b1;
               c_read_enable_nxt = 1'b0;
               state_nxt         = IDLE;
            end else begin
               count_nxt = count - CNT_W'(1);
            end
         end
         default: begin
            c_read_enable_nxt = 1'b0;
            state_nxt         = IDLE;
         end
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         grant         <= '0;
         last_grant    <= LAST_IDX;
         count         <= '0;
         ack           <= '0;
         rdata         <= '0;
         c_ptr         <= '0;
         c_read_enable <= 1'b0;
         busy          <= 1'b0;
      end else begin
         state         <= state_nxt;
         grant         <= grant_nxt;
         last_grant    <= last_grant_nxt;
         count         <= count_nxt;
         ack           <= ack_nxt;
         rdata         <= rdata_nxt;
         c_ptr         <= c_ptr_nxt;
         c_read_enable <= c_read_enable_nxt;
         busy          <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_load_cache_arbiter.sv
// Directed scenarios followed by random traffic, all checked against a transaction-level model.
module tb_load_cache_arbiter;
   localparam int N  = 4;
   localparam int W  = 32;
   localparam int MS = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic [N-1:0]     req;
   logic [N*W-1:0]   req_addr;
   logic [N-1:0]     ack;
   logic [W-1:0]     rdata;
   logic             busy;
   logic [W-1:0]     c_ptr;
   logic             c_read_enable;
   logic [W-1:0]     c_out;
   logic             c_hit;
   logic [W-1:0]     addr [N];

   always #5 clk = ~clk;

   assign req_addr = {addr[3], addr[2], addr[1], addr[0]};

   load_cache_arbiter #(.REQ_NUM(N), .WORD_SIZE(W), .MEM_STALL(MS), .CNT_W(3)) dut (
      .clk(clk), .reset(reset), .req(req), .req_addr(req_addr),
      .ack(ack), .rdata(rdata), .busy(busy), .c_ptr(c_ptr),
      .c_read_enable(c_read_enable), .c_out(c_out), .c_hit(c_hit)
   );

   int checks   = 0;
   int failures = 0;

   // Reference: one outstanding transaction, described by who owns it and how long ago it was granted.
   bit            m_active;
   int            m_who;
   int            m_last;
   int            m_age;
   logic [N-1:0]  m_ack;
   logic [W-1:0]  m_rdata;
   logic [W-1:0]  m_ptr;
   bit            m_en;

   function void model_step();
      logic [N-1:0] prev_ack;
      prev_ack = m_ack;
      m_ack    = '0;
      if (reset) begin
         m_active = 0; m_who = 0; m_last = N - 1; m_age = 0;
         m_rdata  = '0; m_ptr = '0; m_en = 0;
         return;
      end
      if (!m_active) begin
         for (int k = 1; k <= N; k++) begin
            int j;
            j = (m_last + k) % N;
            if (req[j] && !prev_ack[j]) begin
               m_who = j; m_last = j; m_ptr = addr[j];
               m_en = 1; m_active = 1; m_age = 0;
               break;
            end
         end
      end else begin
         m_age++;
         if (!req[m_who]) begin
            m_active = 0; m_en = 0;
         end else if ((m_age == 1 && c_hit) || m_age == 1 + MS) begin
            m_rdata = c_out; m_ack[m_who] = 1'b1;
            m_active = 0; m_en = 0;
         end
      end
   endfunction

   task chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
      chk("ack",     32'(ack),           32'(m_ack));
      chk("rdata",   rdata,              m_rdata);
      chk("c_ptr",   c_ptr,              m_ptr);
      chk("enable",  32'(c_read_enable), 32'(m_en));
      chk("busy",    32'(busy),          32'(m_active));
      chk("onehot",  32'($countones(ack) <= 1), 32'd1);
   endtask

   logic [N-1:0] one_hot0;

   initial begin
      one_hot0 = 4'b0001;
      reset = 1'b1; req = '0; c_hit = 1'b0; c_out = '0;
      for (int i = 0; i < N; i++) addr[i] = '0;
      tick(); tick();
      chk("rst_ack",  32'(ack), 32'd0);
      chk("rst_en",   32'(c_read_enable), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ptr",  c_ptr, 32'd0);

      // single hit
      reset = 1'b0; addr[0] = 32'h10; req = 4'b0001; c_hit = 1'b1; c_out = 32'hAA;
      tick();
      chk("t1_ptr", c_ptr, 32'h10);
      chk("t1_en",  32'(c_read_enable), 32'd1);
      chk("t1_noack", 32'(ack), 32'd0);
      tick();
      chk("t1_ack",   32'(ack), 32'b0001);
      chk("t1_rdata", rdata, 32'hAA);
      req = '0;
      tick();
      chk("t1_busy",   32'(busy), 32'd0);
      chk("t1_ackclr", 32'(ack), 32'd0);

      // miss with full stall
      addr[2] = 32'h40; req = 4'b0100; c_hit = 1'b0; c_out = 32'h55;
      tick();
      chk("t2_ptr", c_ptr, 32'h40);
      chk("t2_en",  32'(c_read_enable), 32'd1);
      repeat (4) begin
         tick();
         chk("t2_wait_ack", 32'(ack), 32'd0);
         chk("t2_wait_en",  32'(c_read_enable), 32'd1);
      end
      tick();
      chk("t2_ack",   32'(ack), 32'b0100);
      chk("t2_rdata", rdata, 32'h55);
      chk("t2_en_off", 32'(c_read_enable), 32'd0);
      req = '0;
      tick();

      // round robin with all requesters busy
      reset = 1'b1; tick(); reset = 1'b0;
      addr[1] = 32'h20; addr[3] = 32'h80; c_hit = 1'b1; c_out = 32'hC0; req = 4'b1111;
      tick();
      for (int t = 0; t < 5; t++) begin
         tick();
         chk("t3_order", 32'(ack), 32'(one_hot0 << (t % 4)));
         req[t % 4] = 1'b0;
         tick();
         req[t % 4] = 1'b1;
      end
      req = '0;
      tick(); tick();

      // ack masking: req held through its own ack cycle
      req = 4'b0010; c_hit = 1'b1;
      tick();
      tick();
      chk("t4_ack", 32'(ack), 32'b0010);
      tick();
      chk("t4_masked_en",   32'(c_read_enable), 32'd0);
      chk("t4_masked_busy", 32'(busy), 32'd0);
      tick();
      chk("t4_regrant_en",  32'(c_read_enable), 32'd1);
      chk("t4_regrant_ptr", c_ptr, 32'h20);
      req = '0;
      tick();
      chk("t4_flush_en", 32'(c_read_enable), 32'd0);
      tick();

      // flush during stall
      req = 4'b1000; c_hit = 1'b0;
      tick();
      chk("t5_ptr", c_ptr, 32'h80);
      tick(); tick();
      req = 4'b0001;
      tick();
      chk("t5_flush_en",  32'(c_read_enable), 32'd0);
      chk("t5_flush_ack", 32'(ack), 32'd0);
      tick();
      chk("t5_next_en",  32'(c_read_enable), 32'd1);
      chk("t5_next_ptr", c_ptr, 32'h10);
      c_hit = 1'b1;
      tick();
      chk("t5_ack", 32'(ack), 32'b0001);
      req = '0;
      tick();

      // reset in the middle of a miss
      c_hit = 1'b0; req = 4'b0100;
      tick(); tick(); tick();
      reset = 1'b1;
      tick();
      chk("t6_ack",   32'(ack), 32'd0);
      chk("t6_rdata", rdata, 32'd0);
      chk("t6_ptr",   c_ptr, 32'd0);
      chk("t6_en",    32'(c_read_enable), 32'd0);
      chk("t6_busy",  32'(busy), 32'd0);
      reset = 1'b0; req = 4'b1001; c_hit = 1'b1; c_out = 32'h77;
      tick();
      chk("t6_first_ptr", c_ptr, 32'h10);
      tick();
      chk("t6_ack0", 32'(ack), 32'b0001);
      chk("t6_rdata0", rdata, 32'h77);
      req = 4'b1000;
      tick();
      chk("t6_second_ptr", c_ptr, 32'h80);
      tick();
      chk("t6_ack3", 32'(ack), 32'b1000);
      req = '0;
      tick();

      // random traffic: requesters obey the hold-until-ack rule, with occasional flushes and resets
      repeat (3000) begin
         reset = ($urandom_range(0, 199) == 0);
         c_hit = 1'($urandom_range(0, 1));
         c_out = $urandom;
         for (int i = 0; i < N; i++) begin
            if (req[i]) begin
               if (m_ack[i]) req[i] = ($urandom_range(0, 3) == 0);
               else if ($urandom_range(0, 63) == 0) req[i] = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
               req[i]  = 1'b1;
               addr[i] = $urandom & 32'hFFFF_FFFC;
            end
         end
         tick();
      end
      reset = 1'b0; req = '0;
      repeat (10) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
